// File: rtl/run_det_pkg.sv
// Shared definitions for the run detector: FSM state encoding and symbol helper.
// No logic of its own; imported by run_detector.
// Binary state encoding keeps the state register at two flops.
package run_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN0 = 2'b01,
        ST_RUN1 = 2'b10
    } run_state_t;

    // Symbol carried by a run state; IDLE reports 0.
    function automatic logic sym_of(input run_state_t st);
        return (st == ST_RUN1);
    endfunction

    // Run state that a fresh run of symbol w lands in.
    function automatic run_state_t run_state_for(input logic w);
        return w ? ST_RUN1 : ST_RUN0;
    endfunction

endpackage

// File: rtl/run_counter.sv
// Run-length up-counter: clear to 0, load 1, increment up to MAX then hold or restart at 1.
// Latency: count updates on the edge that samples clear/load1/inc.
// Backpressure: none; the caller only asserts inc/load1 on qualified samples.
//
// Ports: clock, reset (async, active-high), clear (sync, highest priority),
//        load1 (start a new run), inc (extend the run), restart (at MAX go back
//        to 1 instead of holding), count (current run length).
module run_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load1,
    input  logic         inc,
    input  logic         restart,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_ONE;
        end else if (inc) begin
            if (count == CNT_MAX) begin
                // At full length: either hold (saturating) or begin the next run.
                count <= restart ? CNT_ONE : count;
            end else begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/run_detector.sv
// Serial run detector: flags when the current run of identical symbols reaches RUN_LEN.
// Latency: z rises one edge after the sample that completes the run.
// Backpressure: none; samples with valid=0 are ignored and all state holds.
//
// Ports: clock, reset (async, active-high), clear (sync clear of state and
//        event counter), valid/w (qualified serial symbol), mode (0 saturate,
//        1 restart after each detection), z (run reached RUN_LEN), sym (symbol
//        of current run), run_cnt (current run length), det_cnt (detection
//        events, wraps).
module run_detector
    import run_det_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    parameter  int DET_W   = 8,
    localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic             w,
    input  logic             mode,
    output logic             z,
    output logic             sym,
    output logic [CNT_W-1:0] run_cnt,
    output logic [DET_W-1:0] det_cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(RUN_LEN - 1);

    run_state_t state_q;
    run_state_t state_d;
    logic       load1;
    logic       inc;
    logic       hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load1   = 1'b0;
        inc     = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (valid) begin
            case (state_q)
                ST_RUN0, ST_RUN1: begin
                    if (w != sym_of(state_q)) begin
                        state_d = run_state_for(w);
                        load1   = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                default: begin
                    state_d = run_state_for(w);
                    load1   = 1'b1;
                end
            endcase
        end
    end

    run_counter #(
        .MAX (RUN_LEN),
        .W   (CNT_W)
    ) u_run_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .load1   (load1),
        .inc     (inc),
        .restart (mode),
        .count   (run_cnt)
    );

    // A detection is the step from RUN_LEN-1 to RUN_LEN; a fresh run starts at 1
    // and RUN_LEN >= 2, so load1 can never produce a detection on its own.
    assign hit = inc && (run_cnt == CNT_PRE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            det_cnt <= '0;
        end else if (clear) begin
            det_cnt <= '0;
        end else if (hit) begin
            det_cnt <= det_cnt + 1'b1;
        end
    end

    assign z   = (run_cnt == CNT_FULL);
    assign sym = sym_of(state_q);

endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_LEN, default 4, run length that triggers detection; legal range 2..255.
REQ-002 Parameter DET_W, default 8, width of the detection event counter.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port clear  input  1  synchronous clear of detector state and event counter.
REQ-006 Port valid  input  1  qualifies w; samples with valid=0 are ignored.
REQ-007 Port w  input  1  serial input symbol.
REQ-008 Port mode  input  1  0 = saturating (z held while run continues); 1 = non-overlapping (count restarts after each detection).
REQ-009 Port z  output  1  registered detect flag: current run has reached RUN_LEN.
REQ-010 Port sym  output  1  symbol of the current run (0 in IDLE).
REQ-011 Port run_cnt  output  CNT_W  current run length, CNT_W = clog2(RUN_LEN+1).
REQ-012 Port det_cnt  output  DET_W  number of detection events, wraps modulo 2^DET_W.

Function
REQ-013 State machine states: IDLE, RUN0 (run of zeros), RUN1 (run of ones), binary-encoded.
REQ-014 IDLE + valid sample w -> RUN<w>, run_cnt=1.
REQ-015 RUN<s> + valid sample w!=s -> RUN<w>, run_cnt=1.
REQ-016 RUN<s> + valid w==s, run_cnt<RUN_LEN -> run_cnt+1.
REQ-017 RUN<s> + valid w==s, run_cnt==RUN_LEN, mode=0 -> run_cnt stays RUN_LEN (saturates, never wraps).
REQ-018 RUN<s> + valid w==s, run_cnt==RUN_LEN, mode=1 -> run_cnt=1, state unchanged.
REQ-019 valid=0 -> state, run_cnt, z, det_cnt all hold.
REQ-020 z = (run_cnt==RUN_LEN), derived from registered state; z rises the cycle after the edge that sampled the RUN_LEN-th matching symbol (latency 1 edge).
REQ-021 det_cnt increments by 1 on each edge where run_cnt transitions to RUN_LEN from a smaller value; saturated hold in mode 0 does not increment.
REQ-022 sym equals s in RUN<s>, 0 in IDLE.
REQ-023 mode is sampled on each valid edge; a change takes effect on the next valid sample, no state reset.
REQ-024 clear=1 at an edge -> IDLE, run_cnt=0, det_cnt=0; clear has priority over valid.
REQ-025 det_cnt wraps from 2^DET_W-1 to 0 without affecting z.

Reset
REQ-026 reset=1 asynchronously forces IDLE, run_cnt=0, z=0, sym=0, det_cnt=0.
REQ-027 reset asserted mid-run discards the run; first valid sample after release starts a new run with run_cnt=1.
REQ-028 No output toggles while reset is high regardless of clock, valid or clear.

Structure
REQ-029 State encoding constants (IDLE, RUN0, RUN1) reside in shared package run_det_pkg.
REQ-030 One sub-module run_counter (saturating/restarting up-counter with load-1 and clear) is instantiated for run_cnt; det_cnt is a plain wrapping counter in the top module.
REQ-031 All state elements share one always block style with async reset; no latches, no gated clocks.

Verification (RUN_LEN=4, DET_W=8)
REQ-032 mode=0, valid=1, w=0,0,0,0 -> z=1 after 4th edge, run_cnt=4, det_cnt=1; a 5th 0 keeps z=1, det_cnt=1.
REQ-033 mode=1, w=1 x8 -> z high after edges 4 and 8 only, run_cnt 1,2,3,4,1,2,3,4, det_cnt=2.
REQ-034 w=0,0,0,1,1,1,1 -> z=0 through edge 6, z=1 after edge 7, sym=1, det_cnt=1.
REQ-035 w=0,0 then valid=0 for 5 cycles with w toggling, then w=0,0 -> z=1 after 2nd resumed sample.
REQ-036 reset pulse between clock edges during run_cnt=3 -> outputs 0 immediately; next 4 matching samples give z=1, det_cnt=1.
REQ-037 clear and valid (w=0) together with run_cnt=3 -> IDLE, run_cnt=0, det_cnt=0; 257 detections in mode=1 -> det_cnt=1 (wrap).
